// File: rtl/fmult_accum_pkg.sv
// Shared definitions for the serial FMULT accumulator.
// Holds the float field layout, the FMULT constants, the controller
// state encoding and a bit-length helper used by the multiplier.
package fmult_accum_pkg;

    localparam int NTERMS    = 8;   // b1..b6, a2, a1
    localparam int CW        = 16;  // coefficient width
    localparam int FW        = 11;  // float width
    localparam int OW        = 15;  // estimate width
    localparam int CNT_W     = 3;

    // Float layout: sign [10], exponent [9:6], mantissa [5:0]
    localparam int SIGN_BIT  = 10;
    localparam int EXP_MSB   = 9;
    localparam int EXP_LSB   = 6;
    localparam int MANT_MSB  = 5;
    localparam int MANT_LSB  = 0;

    // FMULT constants
    localparam int ROUND     = 48;
    localparam int EXP_PIVOT = 26;
    localparam int MAG_MASK  = 32767;
    localparam int COEF_MASK = 8191;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Number of significant bits in a 13-bit magnitude (0 for zero).
    function automatic logic [3:0] bit_len13(input logic [12:0] v);
        logic [3:0] len;
        len = 4'd0;
        for (int i = 0; i < 13; i++) begin
            if (v[i]) len = 4'(i + 1);
        end
        return len;
    endfunction

endpackage

// File: rtl/fmult_accum_if.sv
// Operand and result bundle of the FMULT accumulator.
//   master: issues start with coefficients and float history, observes
//           se/sez/busy/done.
//   slave : the accumulator itself.
interface fmult_accum_if;
    import fmult_accum_pkg::*;

    logic          start;
    logic [CW-1:0] b1, b2, b3, b4, b5, b6;
    logic [CW-1:0] a1, a2;
    logic [FW-1:0] dq1, dq2, dq3, dq4, dq5, dq6;
    logic [FW-1:0] sr1, sr2;
    logic [OW-1:0] se;
    logic [OW-1:0] sez;
    logic          busy;
    logic          done;

    modport master (
        output start, b1, b2, b3, b4, b5, b6, a1, a2,
               dq1, dq2, dq3, dq4, dq5, dq6, sr1, sr2,
        input  se, sez, busy, done
    );

    modport slave (
        input  start, b1, b2, b3, b4, b5, b6, a1, a2,
               dq1, dq2, dq3, dq4, dq5, dq6, sr1, sr2,
        output se, sez, busy, done
    );

endinterface

// File: rtl/fmult_accum_fmult.sv
// Combinational G.726 FMULT: one weighted product W from a 16-bit
// two's complement coefficient and an 11-bit float sample.
//   an  : coefficient
//   srn : float sample (sign, 4-bit exponent, 6-bit mantissa)
//   w   : 16-bit two's complement product
module fmult
    import fmult_accum_pkg::*;
(
    input  logic [CW-1:0] an,
    input  logic [FW-1:0] srn,
    output logic [CW-1:0] w
);

    logic        an_s;
    logic [13:0] an_shr;
    logic [14:0] an_neg;
    logic [12:0] an_mag;
    logic [3:0]  an_exp;
    logic [18:0] an_mant_wide;
    logic [5:0]  an_mant;
    logic        sr_s;
    logic [3:0]  sr_exp;
    logic [5:0]  sr_mant;
    logic        w_s;
    logic [4:0]  w_exp;
    logic [12:0] w_prod;
    logic [7:0]  w_mant;
    logic [14:0] w_base;
    logic [16:0] w_up;
    logic [14:0] w_mag;

    // NOTE: every variable gets a value before any branch so no latch is inferred.
    always_comb begin
        an_s   = an[CW-1];
        an_shr = an[CW-1:2];
        an_neg = 15'd16384 - {1'b0, an_shr};
        an_mag = an_s ? 13'(an_neg & 15'(COEF_MASK)) : an_shr[12:0];
        an_exp = bit_len13(an_mag);

        // Normalise the magnitude to a 6-bit mantissa with its MSB set.
        an_mant_wide = {an_mag, 6'b0} >> an_exp;
        an_mant      = (an_mag == 13'd0) ? 6'd32 : an_mant_wide[5:0];

        sr_s    = srn[SIGN_BIT];
        sr_exp  = srn[EXP_MSB:EXP_LSB];
        sr_mant = srn[MANT_MSB:MANT_LSB];

        w_s    = sr_s ^ an_s;
        w_exp  = {1'b0, sr_exp} + {1'b0, an_exp};
        w_prod = 13'(sr_mant) * 13'(an_mant) + 13'(ROUND);
        w_mant = w_prod[11:4];
        w_base = {w_mant, 7'b0};

        w_up  = 17'd0;
        if (w_exp > 5'(EXP_PIVOT)) begin
            w_up  = {2'b00, w_base} << (w_exp - 5'(EXP_PIVOT));
            w_mag = 15'(w_up & 17'(MAG_MASK));
        end else begin
            w_mag = w_base >> (5'(EXP_PIVOT) - w_exp);
        end

        w = w_s ? (16'd0 - {1'b0, w_mag}) : {1'b0, w_mag};
    end

endmodule

// File: rtl/fmult_accum.sv
// Serial FMULT accumulator for the ADPCM predictor.
// On start it captures b1..b6/dq1..dq6, a2/sr2 and a1/sr1, then forms one
// FMULT product per cycle on a shared multiplier, accumulating modulo 2^16.
// sez is taken after the six zero-section terms, se after all eight.
//   clk, reset        : clock, asynchronous active-high reset
//   bus               : operand/result bundle (slave side)
//   scan_*, test_mode : DFT hooks, stitched at synthesis, no function here
module fmult_accum
    import fmult_accum_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    fmult_accum_if.slave   bus,
    input  logic           scan_in0,
    input  logic           scan_in1,
    input  logic           scan_in2,
    input  logic           scan_in3,
    input  logic           scan_in4,
    input  logic           scan_enable,
    input  logic           test_mode,
    output logic           scan_out0,
    output logic           scan_out1,
    output logic           scan_out2,
    output logic           scan_out3,
    output logic           scan_out4
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]      acc_q, acc_d;
    logic [OW-1:0]      se_q, se_d;
    logic [OW-1:0]      sez_q, sez_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               load;

    logic [CW-1:0]      coef_q [NTERMS];
    logic [CW-1:0]      coef_d [NTERMS];
    logic [FW-1:0]      flt_q  [NTERMS];
    logic [FW-1:0]      flt_d  [NTERMS];

    logic [CW-1:0]      w;
    logic [CW-1:0]      sum;

    // Evaluation order: b1..b6 with dq1..dq6, then a2/sr2, then a1/sr1.
    always_comb begin
        coef_d = '{bus.b1, bus.b2, bus.b3, bus.b4, bus.b5, bus.b6, bus.a2, bus.a1};
        flt_d  = '{bus.dq1, bus.dq2, bus.dq3, bus.dq4, bus.dq5, bus.dq6, bus.sr2, bus.sr1};
    end

    fmult u_fmult (
        .an  (coef_q[cnt_q]),
        .srn (flt_q[cnt_q]),
        .w   (w)
    );

    assign sum = acc_q + w;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        se_d    = se_q;
        sez_d   = sez_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        load    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = sum;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(NTERMS - 3)) begin
                    sez_d = sum[CW-1:1];
                end
                if (cnt_q == CNT_W'(NTERMS - 1)) begin
                    se_d    = sum[CW-1:1];
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            se_q    <= '0;
            sez_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            se_q    <= se_d;
            sez_q   <= sez_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // NOTE: operand registers are not reset; they are always loaded on start before use.
    always_ff @(posedge clk) begin
        if (load) begin
            coef_q <= coef_d;
            flt_q  <= flt_d;
        end
    end

    assign bus.se   = se_q;
    assign bus.sez  = sez_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

    // Scan chains are inserted at synthesis; functionally they pass through.
    logic dft_unused;
    assign dft_unused = scan_enable ^ test_mode;
    assign scan_out0  = scan_in0;
    assign scan_out1  = scan_in1;
    assign scan_out2  = scan_in2;
    assign scan_out3  = scan_in3;
    assign scan_out4  = scan_in4;

endmodule

// File: tb/tb_fmult_accum.sv
module tb_fmult_accum;
    import fmult_accum_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] scan_in;
    logic       scan_enable;
    logic       test_mode;
    logic [4:0] scan_out;

    fmult_accum_if ifc ();

    fmult_accum dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (ifc.slave),
        .scan_in0    (scan_in[0]),
        .scan_in1    (scan_in[1]),
        .scan_in2    (scan_in[2]),
        .scan_in3    (scan_in[3]),
        .scan_in4    (scan_in[4]),
        .scan_enable (scan_enable),
        .test_mode   (test_mode),
        .scan_out0   (scan_out[0]),
        .scan_out1   (scan_out[1]),
        .scan_out2   (scan_out[2]),
        .scan_out3   (scan_out[3]),
        .scan_out4   (scan_out[4])
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] se;
        logic [14:0] sez;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_defaults();
        ifc.b1 = '0; ifc.b2 = '0; ifc.b3 = '0; ifc.b4 = '0; ifc.b5 = '0; ifc.b6 = '0;
        ifc.a1 = '0; ifc.a2 = '0;
        ifc.dq1 = 11'h020; ifc.dq2 = 11'h020; ifc.dq3 = 11'h020;
        ifc.dq4 = 11'h020; ifc.dq5 = 11'h020; ifc.dq6 = 11'h020;
        ifc.sr1 = 11'h020; ifc.sr2 = 11'h020;
    endtask

    task automatic set_all_b(input logic [15:0] c, input logic [10:0] f);
        ifc.b1 = c; ifc.b2 = c; ifc.b3 = c; ifc.b4 = c; ifc.b5 = c; ifc.b6 = c;
        ifc.dq1 = f; ifc.dq2 = f; ifc.dq3 = f; ifc.dq4 = f; ifc.dq5 = f; ifc.dq6 = f;
    endtask

    // Start is sampled at edge k; inputs are scrambled right after so any
    // late sampling shows up in the results. done must appear after k+9.
    task automatic run_case(input string name, input logic [14:0] exp_se,
                            input logic [14:0] exp_sez, input bit inject);
        @(negedge clk);
        ifc.start = 1'b1;
        sb.push_back('{se: exp_se, sez: exp_sez, name: name});
        @(negedge clk);
        ifc.start = 1'b0;
        set_defaults();
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) check({name, "_busy_k1"}, 32'(ifc.busy), 32'd1);
            if (i == 8) check({name, "_done_early"}, 32'(ifc.done), 32'd0);
            if (i == 9) begin
                check({name, "_done_k9"}, 32'(ifc.done), 32'd1);
                check({name, "_busy_k9"}, 32'(ifc.busy), 32'd0);
            end
            if (inject && i == 2) begin
                ifc.a1    = 16'h4000;
                ifc.sr1   = 11'h2E0;
                ifc.start = 1'b1;
            end
            if (inject && i == 3) ifc.start = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    // Monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && ifc.done === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: got done=1, expected no completion");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_se"},  32'(ifc.se),  32'(e.se));
                check({e.name, "_sez"}, 32'(ifc.sez), 32'(e.sez));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        reset       = 1'b1;
        scan_in     = '0;
        scan_enable = 1'b0;
        test_mode   = 1'b0;
        ifc.start   = 1'b0;
        set_defaults();
        repeat (3) @(posedge clk);
        #1;
        check("reset_se",   32'(ifc.se),   32'd0);
        check("reset_sez",  32'(ifc.sez),  32'd0);
        check("reset_busy", 32'(ifc.busy), 32'd0);
        check("reset_done", 32'(ifc.done), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        set_defaults();
        run_case("zeros", 15'd0, 15'd0, 1'b0);

        set_defaults(); ifc.a1 = 16'h4000; ifc.sr1 = 11'h2E0;
        run_case("a1_pos", 15'd1072, 15'd0, 1'b0);

        set_defaults(); ifc.a1 = 16'hC000; ifc.sr1 = 11'h2E0;
        run_case("a1_neg", 15'd31696, 15'd0, 1'b0);

        set_defaults(); ifc.b1 = 16'h4000; ifc.dq1 = 11'h2E0;
        run_case("b1_pos", 15'd1072, 15'd1072, 1'b0);

        set_defaults(); set_all_b(16'h4000, 11'h2E0);
        run_case("b_all_pos", 15'd6432, 15'd6432, 1'b0);

        set_defaults(); set_all_b(16'hC000, 11'h2E0);
        run_case("b_all_neg_wrap", 15'd26336, 15'd26336, 1'b0);

        set_defaults(); ifc.a1 = 16'h4000; ifc.sr1 = 11'h3E0;
        run_case("wexp_over_pivot", 15'd768, 15'd0, 1'b0);

        set_defaults(); ifc.a1 = 16'hC000; ifc.sr1 = 11'h6E0;
        run_case("both_neg", 15'd1072, 15'd0, 1'b0);

        set_defaults(); ifc.a2 = 16'h2000; ifc.sr2 = 11'h2E0;
        run_case("a2_only", 15'd536, 15'd0, 1'b0);

        set_defaults(); ifc.a1 = 16'h5000; ifc.sr1 = 11'h2F0;
        run_case("odd_mant", 15'd1968, 15'd0, 1'b0);

        set_defaults(); ifc.b1 = 16'h4000; ifc.dq1 = 11'h2E0;
        run_case("start_while_busy", 15'd1072, 15'd1072, 1'b1);

        // Abort a run with reset at k+4; no completion may follow.
        set_defaults(); ifc.a1 = 16'h4000; ifc.sr1 = 11'h2E0;
        @(negedge clk);
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort_se",   32'(ifc.se),   32'd0);
        check("abort_sez",  32'(ifc.sez),  32'd0);
        check("abort_busy", 32'(ifc.busy), 32'd0);
        check("abort_done", 32'(ifc.done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);

        set_defaults(); ifc.a1 = 16'h4000; ifc.sr1 = 11'h2E0;
        run_case("after_abort", 15'd1072, 15'd0, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fmult_accum.md
Name: fmult_accum

Overview:
- Sits directly downstream of the FLOATB float converter and the DQ float path in the ADPCM per-channel datapath.
- Consumes the 11-bit floating-format history samples (sr1, sr2, dq1..dq6) together with the 16-bit predictor coefficients.
- Forms the G.726 FMULT products serially on one shared multiplier, one product per cycle.
- Accumulates them into the signal estimate se and the zero-section estimate sez.

Parameters:
- NTERMS, 8, number of products per evaluation: b1..b6, then a2, then a1. Fixed by G.726; not for override.
- CW, 16, coefficient width, two's complement.
- FW, 11, float width: sign [10], exponent [9:6], mantissa [5:0].

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request; ignored unless idle
- b1..b6  in  16 each  zero-section coefficients
- a1, a2  in  16 each  pole-section coefficients
- dq1..dq6  in  11 each  float quantized-difference history
- sr1, sr2  in  11 each  float reconstructed-signal history (from FLOATB and its delay)
- se  out  15  signal estimate
- sez  out  15  zero-section estimate
- busy  out  1  high while evaluating
- done  out  1  one-cycle completion pulse
- scan_in0..scan_in4  in  1 each  DFT scan chain inputs
- scan_enable  in  1  DFT scan shift enable
- test_mode  in  1  DFT test mode
- scan_out0..scan_out4  out  1 each  DFT scan chain outputs
- The scan and test ports are stitched at synthesis and have no functional effect.

Behaviour:
- Reset values: se=0, sez=0, busy=0, done=0, accumulator=0, counter=0, FSM in IDLE.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 latches all coefficient and float inputs, clears the accumulator, sets counter=0, goes to RUN.
  - RUN: each cycle adds product[counter] to the 16-bit accumulator, modulo 2^16, then increments counter. Order: idx0..5 = b1..b6 with dq1..dq6, idx6 = a2 with sr2, idx7 = a1 with sr1.
  - End of idx5: sez register <= (acc + WB6) >> 1.
  - End of idx7: se register <= (acc + WA1) >> 1; go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- Latency: start sampled at edge k; se, sez and done valid after edge k+9. busy=1 from edge k+1 through edge k+9.
- se and sez hold their values until the next completion.
- start while busy or in DONE is ignored; it is not queued.
- Inputs changing after the start edge have no effect.
- FMULT per product, coefficient An, float SRn:
  - AnS = An[15].
  - AnMAG = AnS ? (16384 - (An>>2)) & 8191 : An>>2, 13 bits.
  - AnEXP = bit length of AnMAG, 0..13.
  - AnMANT = (AnMAG==0) ? 32 : (AnMAG<<6)>>AnEXP.
  - WS = SRnS ^ AnS.
  - WEXP = SRnEXP + AnEXP, 5 bits.
  - WMANT = (SRnMANT*AnMANT + 48) >> 4, 8 bits.
  - WMAG = WEXP>26 ? ((WMANT<<7)<<(WEXP-26)) & 32767 : (WMANT<<7)>>(26-WEXP).
  - W = WS ? (65536 - WMAG) & 65535 : WMAG.
- Accumulator wrap-around modulo 2^16 is the required behaviour; there is no saturation.
- Asynchronous reset mid-RUN aborts the evaluation. All outputs return to reset values; no done pulse is issued.

Decomposition:
- Shared package holds:
  - float field positions (sign, exponent and mantissa LSB/MSB);
  - FMULT constants (rounding 48, exponent pivot 26, magnitude mask 32767, coefficient mask 8191);
  - state enum {IDLE, RUN, DONE};
  - NTERMS.
- One combinational sub-module, fmult, computes one W from (An, SRn) and is instantiated once.
- Operand muxing, FSM, accumulator and output registers stay in fmult_accum.

Test Plan:
- All coefficients 0, all floats 0x020 -> each W=0; after 9 cycles se=0, sez=0, done pulses once.
- a1=0x4000, sr1=0x2E0, rest zero/0x020 -> WA1=2144; se=1072, sez=0.
- a1=0xC000, sr1=0x2E0 -> WA1=63392; se=31696 (0x7BD0), sez=0.
- b1=0x4000, dq1=0x2E0, rest zero -> sez=1072, se=1072.
- Run the b1 case, pulse start again at cycle k+3 with a1=0x4000, sr1=0x2E0 -> second start ignored; exactly one done pulse at k+9; se=1072.
- Assert reset at cycle k+4 of a run -> se=sez=busy=done=0 immediately; next start runs normally with correct results.
